// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/forwarding controller.
//   - FWD_REGFILE   : forwarding-select code meaning "use the ID/EX value"
//   - shadow-entry flag field widths and bit positions (rd width is a
//     parameter of the users, so only the flag fields live here)
//   - squash vector bit positions
//   - ctrl_mode_e   : decoded per-cycle control mode of the controller
//   - fwd_code()    : maps a matching shadow stage to a forwarding select
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int FWD_REGFILE  = 0;

    // Shadow entry flags: {mem_read, reg_write, valid}
    localparam int SH_FLAG_W    = 3;
    localparam int SH_VALID_BIT = 0;
    localparam int SH_RW_BIT    = 1;
    localparam int SH_MR_BIT    = 2;

    // squash[SQ_IF_ID] clears IF/ID; squash[k] (k >= 1) clears stage-k control.
    localparam int SQ_IF_ID     = 0;

    typedef enum logic [2:0] {
        MODE_OFF,     // disabled or in reset: every enable low
        MODE_FREEZE,  // data memory wait: whole pipe holds
        MODE_FLUSH,   // taken branch: squash younger instructions
        MODE_STALL,   // data hazard: hold PC/IF-ID, bubble into EX
        MODE_RUN      // normal advance
    } ctrl_mode_e;

    // A match in stage s (1..stages-1) forwards the result leaving stage s+1.
    // A WB-stage match is covered by the register file; no match uses ID/EX.
    function automatic int fwd_code(input int stage, input int stages);
        if (stage > 0 && stage < stages) begin
            return stage;
        end
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// -----------------------------------------------------------------------------
// hazard_shadow_stage
// One entry of the destination shadow pipeline (valid, rd, reg_write,
// mem_read). Loads on 'load', holds otherwise; 'clear' together with 'load'
// loads the entry with valid forced low (bubble / squash).
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   load                 advance enable
//   clear                kill the entry being loaded
//   in_flags / in_rd     entry coming from the previous stage (or ID)
//   out_flags / out_rd   registered entry
// -----------------------------------------------------------------------------
module hazard_shadow_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load,
    input  logic                  clear,
    input  logic [SH_FLAG_W-1:0]  in_flags,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic [SH_FLAG_W-1:0]  out_flags,
    output logic [REG_ADDR_W-1:0] out_rd
);

    logic [SH_FLAG_W-1:0]  flags_q, flags_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    always_comb begin
        flags_d = flags_q;
        rd_d    = rd_q;
        if (load) begin
            flags_d = in_flags;
            rd_d    = in_rd;
            if (clear) begin
                flags_d[SH_VALID_BIT] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            flags_q <= '0;
            rd_q    <= '0;
        end else begin
            flags_q <= flags_d;
            rd_q    <= rd_d;
        end
    end

    assign out_flags = flags_q;
    assign out_rd    = rd_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and forwarding controller for the pipelined RISC-V core. Tracks the
// destination info of the instructions in EX..WB in a shadow pipeline and,
// from the ID-stage decode, produces stall/bubble/squash/freeze controls and
// registered forwarding selects for the instruction entering EX.
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   enable                      global run (0: everything holds, outputs 0)
//   id_*                        ID-stage decode (valid, sources, rd, flags)
//   branch_taken                taken branch resolved in stage BR_STAGE
//   mem_ready                   data memory ready (0 freezes the pipe)
//   pc_write, if_id_write       front-end enables
//   id_ex_bubble                zero the ID/EX control
//   squash[BR_STAGE-1:0]        bit0 IF/ID, bit k stage-k control
//   pipe_en                     enable for ID/EX and later registers
//   fwd_sel_a/b                 EX operand source (0 = ID/EX value)
//   stall_cnt, flush_cnt        saturating performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int STAGES         = 3,
    parameter int LOAD_LAT       = 1,
    parameter int BR_STAGE       = 2,
    parameter int REGFILE_BYPASS = 1,
    parameter int CNT_W          = 32,
    parameter int SEL_W          = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic [BR_STAGE-1:0]   squash,
    output logic                  pipe_en,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [SH_FLAG_W-1:0]  sh_flags [1:STAGES];
    logic [REG_ADDR_W-1:0] sh_rd    [1:STAGES];

    ctrl_mode_e mode;
    logic       run;
    logic       flush;
    logic       bubble;

    int         stg_a, stg_b;
    logic       ld_a, ld_b;
    logic       stall_a, stall_b;
    logic       data_stall;

    logic [SEL_W-1:0] fwd_sel_a_q, fwd_sel_a_d;
    logic [SEL_W-1:0] fwd_sel_b_q, fwd_sel_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Shadow pipeline: stage 1 = EX ... stage STAGES = WB
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_stage
            logic [SH_FLAG_W-1:0]  in_flags;
            logic [REG_ADDR_W-1:0] in_rd;
            logic                  clear;

            if (gi == 1) begin : g_from_id
                always_comb begin
                    in_flags               = '0;
                    in_flags[SH_VALID_BIT] = id_valid;
                    in_flags[SH_RW_BIT]    = id_reg_write;
                    in_flags[SH_MR_BIT]    = id_mem_read;
                end
                assign in_rd = id_rd;
                // A bubble or a flush drops the ID instruction.
                assign clear = bubble | flush;
            end else begin : g_from_prev
                // Instructions in stages 1..BR_STAGE-1 are younger than the
                // resolving branch; they are killed as they advance.
                localparam bit KILL_ON_FLUSH = (gi <= BR_STAGE);
                assign in_flags = sh_flags[gi-1];
                assign in_rd    = sh_rd[gi-1];
                assign clear    = flush & KILL_ON_FLUSH;
            end

            hazard_shadow_stage #(
                .REG_ADDR_W (REG_ADDR_W)
            ) u_stage (
                .clk       (clk),
                .arst_n    (arst_n),
                .load      (pipe_en),
                .clear     (clear),
                .in_flags  (in_flags),
                .in_rd     (in_rd),
                .out_flags (sh_flags[gi]),
                .out_rd    (sh_rd[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Source match: scanning oldest to youngest leaves the youngest hit.
    // ------------------------------------------------------------------
    always_comb begin
        stg_a = 0;
        stg_b = 0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int s = STAGES; s >= 1; s--) begin
            if (sh_flags[s][SH_VALID_BIT] && sh_flags[s][SH_RW_BIT]) begin
                if (id_valid && id_rs1_used && (id_rs1 != '0) && (sh_rd[s] == id_rs1)) begin
                    stg_a = s;
                    ld_a  = sh_flags[s][SH_MR_BIT];
                end
                if (id_valid && id_rs2_used && (id_rs2 != '0) && (sh_rd[s] == id_rs2)) begin
                    stg_b = s;
                    ld_b  = sh_flags[s][SH_MR_BIT];
                end
            end
        end
    end

    // The ID instruction reaches EX one cycle later, when its producer sits in
    // stage s+1; a load result only exists from stage 2+LOAD_LAT on.
    assign stall_a = (stg_a != 0) &&
                     ((ld_a && (stg_a + 1 < 2 + LOAD_LAT)) ||
                      ((REGFILE_BYPASS == 0) && (stg_a == STAGES)));
    assign stall_b = (stg_b != 0) &&
                     ((ld_b && (stg_b + 1 < 2 + LOAD_LAT)) ||
                      ((REGFILE_BYPASS == 0) && (stg_b == STAGES)));
    assign data_stall = stall_a | stall_b;

    // ------------------------------------------------------------------
    // Mode decode (reset and enable gate every combinational output)
    // ------------------------------------------------------------------
    always_comb begin
        run  = enable & arst_n;
        mode = MODE_RUN;
        if (!run) begin
            mode = MODE_OFF;
        end else if (!mem_ready) begin
            mode = MODE_FREEZE;
        end else if (branch_taken) begin
            mode = MODE_FLUSH;
        end else if (data_stall) begin
            mode = MODE_STALL;
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_en      = 1'b0;
        squash       = '0;
        case (mode)
            MODE_RUN: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                pipe_en     = 1'b1;
            end
            MODE_FLUSH: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                pipe_en     = 1'b1;
                for (int k = SQ_IF_ID; k < BR_STAGE; k++) begin
                    squash[k] = 1'b1;
                end
            end
            MODE_STALL: begin
                id_ex_bubble = 1'b1;
                pipe_en      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign flush  = (mode == MODE_FLUSH);
    assign bubble = (mode == MODE_STALL);

    // ------------------------------------------------------------------
    // Forwarding selects and counters
    // ------------------------------------------------------------------
    always_comb begin
        fwd_sel_a_d = fwd_sel_a_q;
        fwd_sel_b_d = fwd_sel_b_q;
        if (pipe_en) begin
            if (bubble || flush) begin
                fwd_sel_a_d = '0;
                fwd_sel_b_d = '0;
            end else begin
                fwd_sel_a_d = SEL_W'(fwd_code(stg_a, STAGES));
                fwd_sel_b_d = SEL_W'(fwd_code(stg_b, STAGES));
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (((mode == MODE_FREEZE) || (mode == MODE_STALL)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fwd_sel_a_q <= '0;
            fwd_sel_b_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fwd_sel_a_q <= fwd_sel_a_d;
            fwd_sel_b_q <= fwd_sel_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_sel_a = fwd_sel_a_q;
    assign fwd_sel_b = fwd_sel_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
